// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front end between the raw board push-buttons and the game core. Each of the
// five buttons gets its own channel: a two-flop synchroniser, a debounce FSM,
// a registered clean level, and one-cycle press / release strobes. The game
// core uses only these outputs and never the raw pins.
//
// Bit mapping (all ports): bit0=btnS, bit1=btnR, bit2=btnL, bit3=btnU, bit4=btnD
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          synchronous, active-high reset
//   btn_raw      raw asynchronous buttons, active-high
//   btn_level    debounced level per button
//   btn_press    one-cycle strobe per accepted press (and per auto-repeat)
//   btn_release  one-cycle strobe per accepted release
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a change (>= 1)
//   REPEAT_DELAY     cycles from the press strobe to the first repeat strobe
//   REPEAT_PERIOD    cycles between later repeat strobes
//
// Build option:
//   BTN_AUTO_REPEAT_EN  when defined, a held button emits further btn_press
//                       strobes after REPEAT_DELAY and then every
//                       REPEAT_PERIOD cycles. When undefined there is exactly
//                       one btn_press per accepted press.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_press,
  output logic [4:0] btn_release
);

  localparam int NUM_BTN = 5;

  // One counter width serves both the debounce and the repeat timers.
  localparam int MAX_A   = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_CYC = (MAX_A > REPEAT_PERIOD) ? MAX_A : REPEAT_PERIOD;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  // With a single-cycle debounce the wait states are skipped entirely.
  localparam bit DEB_ONE = (DEBOUNCE_CYCLES <= 1);

`ifdef BTN_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);
`endif

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser; only sync2_q is allowed to reach the FSMs.
  // ---------------------------------------------------------------------------
  logic [NUM_BTN-1:0] sync1_q;
  logic [NUM_BTN-1:0] sync2_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of the others (sync2_q gets the old
  // sync1_q, not the value being loaded on this same edge).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-button channel
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan

    btn_state_e       state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             level_q,   level_d;
    logic             press_q,   press_d;
    logic             release_q, release_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_hit;
    logic             rpt_fire;

    // Saturating increment; ">=" keeps the accept decision correct even if
    // the counter ever sits at its ceiling.
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    assign cnt_hit = (cnt_inc >= DEB_LIM);

    // Debounce FSM: next state and strobes.
    // NOTE: every signal driven here gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (sync2_q[g]) begin
            if (DEB_ONE) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              state_d = ST_PRESS_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end

        ST_PRESS_WAIT: begin
          if (sync2_q[g]) begin
            if (cnt_hit) begin
              state_d = ST_HELD;
              cnt_d   = '0;
              level_d = 1'b1;
              press_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Glitch shorter than the debounce window: drop it silently.
            state_d = ST_IDLE;
            cnt_d   = '0;
          end
        end

        ST_HELD: begin
          if (!sync2_q[g]) begin
            if (DEB_ONE) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              state_d = ST_RELEASE_WAIT;
              cnt_d   = CNT_ONE;
            end
          end
        end

        ST_RELEASE_WAIT: begin
          if (!sync2_q[g]) begin
            if (cnt_hit) begin
              state_d   = ST_IDLE;
              cnt_d     = '0;
              level_d   = 1'b0;
              release_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Release bounce: back to HELD without a new press strobe.
            state_d = ST_HELD;
            cnt_d   = '0;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end

`ifdef BTN_AUTO_REPEAT_EN
    // Repeat timer: starts at the initial press strobe, survives release
    // bounces (HELD <-> RELEASE_WAIT), and is cleared when the channel
    // returns to IDLE. rpt_periodic_q selects between the first delay and
    // the steady repeat period.
    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_periodic_q, rpt_periodic_d;
    logic [CNT_W-1:0] rpt_inc;
    logic [CNT_W-1:0] rpt_lim;
    logic             rpt_active;

    assign rpt_inc    = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;
    assign rpt_lim    = rpt_periodic_q ? RPT_PER : RPT_DLY;
    // The edge that accepts a release never repeats, so press and release
    // cannot share a cycle.
    assign rpt_active = ((state_q == ST_HELD) || (state_q == ST_RELEASE_WAIT))
                        && (state_d != ST_IDLE);

    always_comb begin
      rpt_cnt_d      = '0;
      rpt_periodic_d = 1'b0;
      rpt_fire       = 1'b0;
      if (press_d) begin
        rpt_cnt_d      = '0;
        rpt_periodic_d = 1'b0;
      end else if (rpt_active) begin
        rpt_periodic_d = rpt_periodic_q;
        if (rpt_inc >= rpt_lim) begin
          rpt_fire       = 1'b1;
          rpt_cnt_d      = '0;
          rpt_periodic_d = 1'b1;
        end else begin
          rpt_cnt_d = rpt_inc;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rpt_cnt_q      <= '0;
        rpt_periodic_q <= 1'b0;
      end else begin
        rpt_cnt_q      <= rpt_cnt_d;
        rpt_periodic_q <= rpt_periodic_d;
      end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    // NOTE: the reset clears every flop of the channel, including the debounce
    // counter, so a reset in the middle of a debounce really restarts it.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d | rpt_fire;
        release_q <= release_d;
      end
    end

    assign btn_level[g]   = level_q;
    assign btn_press[g]   = press_q;
    assign btn_release[g] = release_q;
  end : g_chan

endmodule : button_conditioner
